norm_cdf_sched: RTL and testbench
=================================

Name: norm_cdf_sched

Overview:
- Shared-access scheduler and interpolation sequencer for the standard-normal CDF lookup table (513 x 16-bit entries, N(z) for z in [0,8] in steps of 1/64, Q0.16).
- Two requesters share the one table: port 0 evaluates N(d1), port 1 evaluates N(d2).
- Each accepted request is converted to a table address and fraction, and the table pair (val1 = entry[addr], val2 = entry[addr+1], with val2 = val1 at addr 512) is read.
- Returns a linearly interpolated, sign-corrected N(x), tagged with the requester index, through a stallable 3-stage pipeline.

Parameters:
- XW, 16, width of signed input x, fixed-point Q5.10 (value = x/1024).
- YW, 16, width of result and table entries, Q0.16 unsigned.
- AW, 10, table address width.
- CW, 16, width of the completed-lookup counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  2  per-requester request valid.
- req_x0  in  XW  requester 0 argument (signed Q5.10).
- req_x1  in  XW  requester 1 argument (signed Q5.10).
- req_ready  out  2  per-requester accept; a transfer occurs when req_valid[i] && req_ready[i].
- rom_addr  out  AW  table address, driven from a stage-1 register.
- rom_val1  in  YW  table entry at rom_addr, combinational.
- rom_val2  in  YW  table entry at rom_addr+1 (equal to rom_val1 at 512), combinational.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  YW  N(x), Q0.16.
- out_tag  out  1  requester index of out_data.
- lookups_done  out  CW  count of completed output transfers; wraps modulo 2^CW.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - All stage-valid bits are cleared; out_valid=0, out_data=0, out_tag=0, rom_addr=0.
  - lookups_done=0; rr_last=1, so requester 0 has first priority.
  - In-flight requests are discarded without output. req_ready=0 while rst is high.
- Global advance: adv = !out_valid || out_ready. When adv=0 every stage register holds its value and req_ready=00.
- Arbitration (stage 0, combinational grant):
  - One valid request: grant it.
  - Both valid: grant requester 0 if rr_last=1, else requester 1.
  - req_ready[i] = adv && grant[i]; at most one bit is set.
  - On a transfer, rr_last takes the granted index. Simultaneous requests therefore alternate 0,1,0,1.
- Stage 1 register, loaded on a transfer when adv:
  - sign = x[XW-1]; a = |x| as a 16-bit unsigned value, so -32768 gives 32768.
  - If a >= 8192: addr=512, frac=0 (clamp). Otherwise addr = a[12:4] zero-extended, frac = a[3:0].
  - rom_addr = stage-1 addr. Stage-1 valid is cleared when adv and there is no transfer.
- Stage 2, on adv: capture v1=rom_val1, v2=rom_val2, frac, sign, tag, valid.
- Stage 3, on adv (output register):
  - d = v2 - v1 as a 17-bit signed value; p = d * frac as a 21-bit signed value.
  - y = v1 + (p >>> 4), truncated to 16 bits. There is no overflow for a monotone table.
  - out_data = sign ? ~y : y, i.e. 0xFFFF - y.
  - out_valid = stage-2 valid; out_tag = tag.
- Latency: a request accepted at edge k produces out_valid=1 after edge k+3 when there is no stall. Throughput is 1 per cycle.
- Output handshake: out_data and out_tag are held stable while out_valid && !out_ready. lookups_done increments on every out_valid && out_ready.
- Zero input: x=0 yields rom[0] with no sign correction. x=-0 cannot occur in two's complement.

Test Plan:
- Use a table model with rom[n] = 0x8000 + 64*n, rom[512] = 0xFFFF. Out of reset, drive req_x0=0, valid 1 cycle -> after 3 cycles out_data=0x8000, out_tag=0, lookups_done=1.
- req_x1=0x0418 (abs 1048: addr 65, frac 8) -> rom_addr=65, out_data = 0x8000+64*65+32 = 0x9060, out_tag=1.
- req_x0=0xFC00 (-1.0: addr 64, frac 0) -> out_data = ~0x9000 = 0x6FFF. req_x0=0x7FFF -> addr 512, out_data=0xFFFF. req_x0=0x8000 -> addr 512, out_data=0x0000.
- Both requesters valid continuously with out_ready=1 -> grants 0,1,0,1,... one per cycle; out_tag sequence 0,1,0,1 starting 3 cycles after the first grant.
- Stream 4 requests, hold out_ready=0 for 5 cycles once out_valid rises -> req_ready=00, out_data and out_tag constant. On release, 4 results emerge in order with no loss or duplicate, and lookups_done=4.
- Assert rst for 1 cycle with 2 lookups in flight -> next cycle out_valid=0 and lookups_done=0. The discarded lookups never appear; a new request completes normally with a 3-cycle latency.

Source files
------------

// File: rtl/norm_cdf_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : norm_cdf_sched_if
// Brief    : Request, table-read and result signals of the N(x) lookup scheduler.
// Revision : 1.0
// ============================================================================
interface norm_cdf_sched_if #(
    parameter int XW = 16,
    parameter int YW = 16,
    parameter int AW = 10,
    parameter int CW = 16
);
    logic [1:0]    req_valid;
    logic [XW-1:0] req_x0;
    logic [XW-1:0] req_x1;
    logic [1:0]    req_ready;
    logic [AW-1:0] rom_addr;
    logic [YW-1:0] rom_val1;
    logic [YW-1:0] rom_val2;
    logic          out_valid;
    logic          out_ready;
    logic [YW-1:0] out_data;
    logic          out_tag;
    logic [CW-1:0] lookups_done;

    modport slave (
        input  req_valid, req_x0, req_x1, rom_val1, rom_val2, out_ready,
        output req_ready, rom_addr, out_valid, out_data, out_tag, lookups_done
    );

    modport master (
        output req_valid, req_x0, req_x1, rom_val1, rom_val2, out_ready,
        input  req_ready, rom_addr, out_valid, out_data, out_tag, lookups_done
    );
endinterface
`default_nettype wire

// File: rtl/norm_cdf_sched.sv
`default_nettype none
// ============================================================================
// Module   : norm_cdf_sched
// Brief    : Two-port arbiter and 3-stage interpolating sequencer for N(x).
// Revision : 1.0
// ============================================================================
module norm_cdf_sched #(
    parameter int XW = 16,
    parameter int YW = 16,
    parameter int AW = 10,
    parameter int CW = 16
) (
    input  logic               clk,
    input  logic               rst,
    norm_cdf_sched_if.slave    bus
);
    localparam int PW = YW + 5;

    // ---------------- stage 0: arbitration ----------------
    logic          rr_last_q;
    logic          out_valid_q;
    logic          w_adv;
    logic [1:0]    w_grant;
    logic [1:0]    w_ready;
    logic          w_xfer;
    logic          w_gidx;

    assign w_adv = !out_valid_q || bus.out_ready;

    always_comb begin
        w_grant = 2'b00;
        case (bus.req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = rr_last_q ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    assign w_ready       = {2{w_adv && !rst}} & w_grant;
    assign bus.req_ready = w_ready;
    assign w_xfer        = |(bus.req_valid & w_ready);
    assign w_gidx        = w_grant[1];

    // Address/fraction split of |x|; anything at or beyond z=8 pins to the last entry.
    logic [XW-1:0] w_x;
    logic          sign_d;
    logic [XW-1:0] w_abs;
    logic          w_clamp;
    logic [AW-1:0] addr_d;
    logic [3:0]    frac_d;

    assign w_x     = w_gidx ? bus.req_x1 : bus.req_x0;
    assign sign_d  = w_x[XW-1];
    assign w_abs   = sign_d ? (-w_x) : w_x;
    assign w_clamp = |w_abs[XW-1:13];
    assign addr_d  = w_clamp ? AW'(512) : AW'(w_abs[12:4]);
    assign frac_d  = w_clamp ? 4'd0 : w_abs[3:0];

    // ---------------- stage 1 ----------------
    logic          s1_valid_q;
    logic [AW-1:0] s1_addr_q;
    logic [3:0]    s1_frac_q;
    logic          s1_sign_q;
    logic          s1_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_frac_q  <= '0;
            s1_sign_q  <= 1'b0;
            s1_tag_q   <= 1'b0;
            rr_last_q  <= 1'b1;
        end else if (w_adv) begin
            s1_valid_q <= w_xfer;
            if (w_xfer) begin
                s1_addr_q <= addr_d;
                s1_frac_q <= frac_d;
                s1_sign_q <= sign_d;
                s1_tag_q  <= w_gidx;
                rr_last_q <= w_gidx;
            end
        end
    end

    assign bus.rom_addr = s1_addr_q;

    // ---------------- stage 2: table pair capture ----------------
    logic          s2_valid_q;
    logic [YW-1:0] s2_v1_q;
    logic [YW-1:0] s2_v2_q;
    logic [3:0]    s2_frac_q;
    logic          s2_sign_q;
    logic          s2_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_v1_q    <= '0;
            s2_v2_q    <= '0;
            s2_frac_q  <= '0;
            s2_sign_q  <= 1'b0;
            s2_tag_q   <= 1'b0;
        end else if (w_adv) begin
            s2_valid_q <= s1_valid_q;
            s2_v1_q    <= bus.rom_val1;
            s2_v2_q    <= bus.rom_val2;
            s2_frac_q  <= s1_frac_q;
            s2_sign_q  <= s1_sign_q;
            s2_tag_q   <= s1_tag_q;
        end
    end

    // ---------------- stage 3: interpolate and mirror ----------------
    logic signed [YW:0]   w_d;
    logic signed [PW-1:0] w_p;
    logic [YW-1:0]        w_y;
    logic [YW-1:0]        out_data_d;

    assign w_d = $signed({1'b0, s2_v2_q}) - $signed({1'b0, s2_v1_q});
    assign w_p = PW'(w_d) * $signed({{(YW+1){1'b0}}, s2_frac_q});
    assign w_y = s2_v1_q + YW'(w_p >>> 4);
    // N(-z) = 1 - N(z); in Q0.16 the one's complement gives 0xFFFF - y.
    assign out_data_d = s2_sign_q ? ~w_y : w_y;

    logic [YW-1:0] out_data_q;
    logic          out_tag_q;
    logic [CW-1:0] lookups_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= 1'b0;
        end else if (w_adv) begin
            out_valid_q <= s2_valid_q;
            out_data_q  <= out_data_d;
            out_tag_q   <= s2_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            lookups_q <= lookups_q + CW'(1);
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_tag      = out_tag_q;
    assign bus.lookups_done = lookups_q;
endmodule
`default_nettype wire

// File: tb/tb_norm_cdf_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_norm_cdf_sched
// Brief    : Directed self-checking bench for norm_cdf_sched with a linear test table.
// Revision : 1.0
// ============================================================================
module tb_norm_cdf_sched;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   done_exp = 0;

    always #5 clk = ~clk;

    norm_cdf_sched_if #(.XW(16), .YW(16), .AW(10), .CW(16)) bus ();

    norm_cdf_sched #(.XW(16), .YW(16), .AW(10), .CW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Test table: rom[n] = 0x8000 + 64*n, rom[512] = 0xFFFF.
    function automatic logic [15:0] rom_f(input logic [10:0] a);
        logic [31:0] v;
        v = 32'h8000 + 32'(a) * 32'd64;
        return (a >= 11'd512) ? 16'hFFFF : v[15:0];
    endfunction

    assign bus.rom_val1 = rom_f({1'b0, bus.rom_addr});
    assign bus.rom_val2 = rom_f({1'b0, bus.rom_addr} + 11'd1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single request through an idle pipeline, checking latency, address and result.
    task automatic one(input bit p, input logic [15:0] x, input logic [9:0] ea,
                       input logic [15:0] e, input string nm);
        if (p) bus.req_x1 = x;
        else   bus.req_x0 = x;
        bus.req_valid = p ? 2'b10 : 2'b01;
        #1;
        chk({nm, "_rdy"}, 32'(bus.req_ready), p ? 32'd2 : 32'd1);
        step();
        bus.req_valid = 2'b00;
        chk({nm, "_addr"}, 32'(bus.rom_addr), 32'(ea));
        chk({nm, "_v1"}, 32'(bus.out_valid), 32'd0);
        step();
        chk({nm, "_v2"}, 32'(bus.out_valid), 32'd0);
        step();
        chk({nm, "_v3"}, 32'(bus.out_valid), 32'd1);
        chk({nm, "_data"}, 32'(bus.out_data), 32'(e));
        chk({nm, "_tag"}, 32'(bus.out_tag), 32'(p));
        step();
        done_exp++;
        chk({nm, "_done"}, 32'(bus.lookups_done), 32'(done_exp));
        chk({nm, "_v4"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sendq[$];
        logic [15:0] expq[$];
        int          idx;
        int          stall_left;
        bit          started;
        bit          xf;

        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_x0    = 16'h0000;
        bus.req_x1    = 16'h0000;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        rst           = 1'b0;
        bus.req_valid = 2'b00;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_tag", 32'(bus.out_tag), 32'd0);
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_done", 32'(bus.lookups_done), 32'd0);

        one(1'b0, 16'h0000, 10'd0,   16'h8000, "zero");
        one(1'b1, 16'h0418, 10'd65,  16'h9060, "pos");
        one(1'b0, 16'hFC00, 10'd64,  16'h6FFF, "neg");
        one(1'b0, 16'h7FFF, 10'd512, 16'hFFFF, "max");
        one(1'b0, 16'h8000, 10'd512, 16'h0000, "min");
        one(1'b0, 16'h1FFF, 10'd511, 16'hFFFB, "edge");
        one(1'b0, 16'h2000, 10'd512, 16'hFFFF, "clamp");
        one(1'b1, 16'hFFFF, 10'd0,   16'h7FFB, "m1");

        // Both requesters continuously valid: last grant was port 1, so port 0 goes first.
        bus.req_x0 = 16'h0000;
        bus.req_x1 = 16'h0400;
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = (i < 6) ? 2'b11 : 2'b00;
            #1;
            if (i < 6)
                chk("arb_rdy", 32'(bus.req_ready), (i % 2 == 1) ? 32'd2 : 32'd1);
            if (i >= 3 && i <= 8) begin
                chk("arb_valid", 32'(bus.out_valid), 32'd1);
                chk("arb_tag", 32'(bus.out_tag), 32'((i - 3) % 2));
                chk("arb_data", 32'(bus.out_data), ((i - 3) % 2 == 1) ? 32'h9000 : 32'h8000);
            end else begin
                chk("arb_idle", 32'(bus.out_valid), 32'd0);
            end
            step();
        end
        done_exp += 6;
        chk("arb_done", 32'(bus.lookups_done), 32'(done_exp));

        // Stream of four with a 5-cycle consumer stall once the first result appears.
        sendq      = '{16'h0000, 16'h0418, 16'hFC00, 16'h0040};
        expq       = '{16'h8000, 16'h9060, 16'h6FFF, 16'h8100};
        idx        = 0;
        stall_left = 5;
        started    = 1'b0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            bus.req_valid = (sendq.size() > 0) ? 2'b01 : 2'b00;
            bus.req_x0    = (sendq.size() > 0) ? sendq[0] : 16'h0000;
            if (!started && bus.out_valid) started = 1'b1;
            if (started && stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            #1;
            if (!bus.out_ready) begin
                chk("stall_rdy", 32'(bus.req_ready), 32'd0);
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_data", 32'(bus.out_data), 32'(expq[idx]));
                chk("stall_tag", 32'(bus.out_tag), 32'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("stream_data", 32'(bus.out_data), 32'(expq[idx]));
                chk("stream_tag", 32'(bus.out_tag), 32'd0);
                idx++;
            end
            xf = bus.req_valid[0] && bus.req_ready[0];
            step();
            if (xf) void'(sendq.pop_front());
        end
        bus.req_valid = 2'b00;
        bus.out_ready = 1'b1;
        chk("stream_count", 32'(idx), 32'd4);
        chk("stream_stalled", 32'(stall_left), 32'd0);
        done_exp += 4;
        chk("stream_done", 32'(bus.lookups_done), 32'(done_exp));
        #1;
        chk("stream_empty", 32'(bus.out_valid), 32'd0);

        // Reset with two lookups in flight: they must vanish.
        bus.req_x0    = 16'h0418;
        bus.req_valid = 2'b01;
        step();
        bus.req_x1    = 16'h0400;
        bus.req_valid = 2'b10;
        step();
        bus.req_valid = 2'b00;
        rst           = 1'b1;
        step();
        rst           = 1'b0;
        done_exp      = 0;
        #1;
        chk("flush_done", 32'(bus.lookups_done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("flush_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        one(1'b0, 16'h0040, 10'd4, 16'h8100, "post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
